noc_flit_tx: RTL and testbench

Credit-based flit transmitter: the injection-side counterpart that drives a router input port's valid_i/data_i and consumes the router's credit_o return.
- Buffers flits from a local producer in a small FIFO.
- Launches one flit per cycle while downstream credits remain.
- Tracks credits returned by the router one per freed buffer slot.
- Sits between a network-interface producer and a router input port.

---
 rtl/noc_flit_tx.sv | 107 ++++++++++
 tb/tb_noc_flit_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_tx.sv
// rtl/noc_flit_tx.sv - credit-based flit transmitter with local FIFO
// Launches one registered flit per cycle while the FIFO holds data and router credits remain.
module noc_flit_tx #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CREDITS    = 4,
   localparam int CNT_W     = $clog2(CREDITS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   output logic              full_o,
   output logic              empty_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              credit_i,
   output logic [CNT_W-1:0]  credits_o,
   output logic              err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [CNT_W-1:0]  credits_q, credits_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic              push_ok;
   logic              send;

   always_comb begin
      push_ok   = push_i && (count_q != DEPTH_C);
      // Decision uses the registered credit count, so a returned credit helps one edge later.
      send      = (count_q != '0) && (credits_q != '0);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      credits_d = credits_q;
      err_d     = err_q;
      valid_d   = send;
      data_d    = data_q;

      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (send) begin
         data_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, send})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (send && !credit_i) begin
         credits_d = credits_q - 1'b1;
      end else if (!send && credit_i) begin
         if (credits_q == CREDITS_C) begin
            err_d = 1'b1;
         end else begin
            credits_d = credits_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         credits_q <= CREDITS_C;
         valid_q   <= 1'b0;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         credits_q <= credits_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         err_q     <= err_d;
      end
   end

   assign full_o    = (count_q == DEPTH_C);
   assign empty_o   = (count_q == '0);
   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign credits_o = credits_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_noc_flit_tx.sv
// tb/tb_noc_flit_tx.sv - directed self-checking bench for noc_flit_tx
module tb_noc_flit_tx;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              push_i;
   logic [DATA_W-1:0] push_data_i;
   logic              full_o;
   logic              empty_o;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;
   logic              credit_i;
   logic [CNT_W-1:0]  credits_o;
   logic              err_o;

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] got [$];
   logic              seen;

   always #5 clk = ~clk;

   noc_flit_tx #(.DATA_W(16), .FIFO_DEPTH(4), .CREDITS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_i),
      .push_data_i (push_data_i),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .credit_i    (credit_i),
      .credits_o   (credits_o),
      .err_o       (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; push_i = 1'b0; push_data_i = '0; credit_i = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_credits", credits_o, 4);
      chk("rst_err", err_o, 0);
      chk("rst_full", full_o, 0);
      chk("rst_empty", empty_o, 1);

      // single flit latency
      push_i = 1'b1; push_data_i = 16'hA001;
      tick();
      push_i = 1'b0;
      chk("lat_empty_after_push", empty_o, 0);
      chk("lat_valid_early", valid_o, 0);
      tick();
      chk("lat_valid", valid_o, 1);
      chk("lat_data", data_o, 16'hA001);
      chk("lat_credits", credits_o, 3);
      chk("lat_empty", empty_o, 1);
      tick();
      chk("lat_valid_drop", valid_o, 0);
      chk("lat_data_hold", data_o, 16'hA001);
      credit_i = 1'b1;
      tick();
      credit_i = 1'b0;
      chk("lat_credit_back", credits_o, 4);
      chk("lat_no_err", err_o, 0);

      // burst of 6 with no credit return
      for (int i = 1; i <= 6; i++) begin
         push_i = 1'b1; push_data_i = DATA_W'(i);
         tick();
         if (i >= 2 && i <= 5) begin
            chk("burst_valid", valid_o, 1);
            chk("burst_data", data_o, i - 1);
         end
      end
      push_i = 1'b0;
      chk("burst_stall_valid", valid_o, 0);
      chk("burst_stall_data", data_o, 4);
      chk("burst_credits0", credits_o, 0);
      chk("burst_held_empty", empty_o, 0);
      tick();
      chk("burst_still_stalled", valid_o, 0);
      credit_i = 1'b1;
      tick();
      credit_i = 1'b0;
      chk("credit_edge_no_send", valid_o, 0);
      chk("credit_edge_credits", credits_o, 1);
      tick();
      chk("resume_valid", valid_o, 1);
      chk("resume_data", data_o, 5);
      chk("resume_credits", credits_o, 0);
      tick();
      chk("resume_valid_drop", valid_o, 0);
      chk("flit6_held", empty_o, 0);

      // fill while out of credits, overflow push dropped
      for (int i = 0; i < 3; i++) begin
         push_i = 1'b1; push_data_i = DATA_W'(16'h11 + i);
         tick();
      end
      chk("fill_full", full_o, 1);
      push_data_i = 16'hDEAD;
      tick();
      push_i = 1'b0;
      chk("drop_full", full_o, 1);
      got.delete();
      for (int k = 0; k < 8; k++) begin
         credit_i = (k < 4);
         tick();
         if (valid_o) got.push_back(data_o);
      end
      credit_i = 1'b0;
      chk("drop_count", got.size(), 4);
      if (got.size() == 4) begin
         chk("drop_order0", got[0], 16'h0006);
         chk("drop_order1", got[1], 16'h0011);
         chk("drop_order2", got[2], 16'h0012);
         chk("drop_order3", got[3], 16'h0013);
      end
      chk("drop_empty", empty_o, 1);
      chk("drop_credits", credits_o, 0);

      // restore credits, then steady stream with 1-cycle loopback
      credit_i = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      credit_i = 1'b0;
      chk("restore_credits", credits_o, 4);
      chk("restore_err", err_o, 0);
      got.delete();
      for (int k = 0; k < 20; k++) begin
         push_i = (k < 16);
         push_data_i = DATA_W'(16'h100 + k);
         credit_i = valid_o;
         tick();
         if (valid_o) got.push_back(data_o);
         if (k >= 1 && k <= 16) chk("stream_valid", valid_o, 1);
         if (k >= 1) chk("stream_credits_nz", credits_o != 0, 1);
      end
      push_i = 1'b0; credit_i = 1'b0;
      chk("stream_count", got.size(), 16);
      for (int i = 0; i < got.size() && i < 16; i++) chk("stream_order", got[i], 16'h100 + i);
      chk("stream_err", err_o, 0);
      chk("stream_credits_end", credits_o, 4);

      // credit overflow
      credit_i = 1'b1;
      tick();
      credit_i = 1'b0;
      chk("ovf_err", err_o, 1);
      chk("ovf_credits", credits_o, 4);
      tick();
      chk("ovf_sticky", err_o, 1);
      push_i = 1'b1; push_data_i = 16'hBEEF;
      tick();
      push_i = 1'b0;
      tick();
      chk("ovf_traffic_valid", valid_o, 1);
      chk("ovf_traffic_data", data_o, 16'hBEEF);
      chk("ovf_traffic_credits", credits_o, 3);
      chk("ovf_traffic_err", err_o, 1);
      credit_i = 1'b1;
      tick();
      credit_i = 1'b0;
      chk("ovf_return_credits", credits_o, 4);
      chk("ovf_return_err", err_o, 1);

      // reset with 3 buffered flits and 1 credit
      for (int i = 1; i <= 7; i++) begin
         push_i = 1'b1; push_data_i = DATA_W'(16'h200 + i);
         tick();
      end
      push_i = 1'b0;
      chk("pre_rst_credits0", credits_o, 0);
      credit_i = 1'b1;
      tick();
      credit_i = 1'b0;
      chk("pre_rst_credits1", credits_o, 1);
      chk("pre_rst_nonempty", empty_o, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", valid_o, 0);
      chk("mid_rst_empty", empty_o, 1);
      chk("mid_rst_credits", credits_o, 4);
      chk("mid_rst_err", err_o, 0);
      chk("mid_rst_data", data_o, 0);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         seen = seen | valid_o;
      end
      chk("post_rst_no_emit", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
